// File: rtl/conv_gpio_sequencer.sv
// GPIO control-word sequencer for the convolution top level: reset pulse, three-memory
// image load from a handshaked pixel stream, then the convolution run with a timeout.
module conv_gpio_sequencer #(
    parameter int GPIO_D    = 32,
    parameter int RAM_WIDTH = 13,
    parameter int NB_IMAGE  = 10,
    parameter int RST_CYC   = 4,
    parameter int TIMEOUT   = 4096
) (
    input  logic                 CLK100MHZ,
    input  logic                 i_reset_n,
    input  logic                 i_start,
    input  logic [NB_IMAGE-1:0]  i_imgLength,
    input  logic [RAM_WIDTH-1:0] i_pix,
    input  logic                 i_pix_valid,
    output logic                 o_pix_ready,
    input  logic                 i_eop,
    input  logic [GPIO_D-1:0]    i_gpio_rd,
    output logic [GPIO_D-1:0]    o_gpio_word,
    output logic [RAM_WIDTH-1:0] o_result,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);
    localparam int RCW = $clog2(RST_CYC + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);

    localparam logic [7:0] RST_CONV  = 8'h01;
    localparam logic [7:0] K_I       = 8'h02;
    localparam logic [7:0] RST_FSM   = 8'h04;
    localparam logic [7:0] SOP       = 8'h08;
    localparam logic [7:0] VALID_FSM = 8'h10;
    localparam logic [7:0] LOAD      = 8'h80;

    typedef enum logic [2:0] {IDLE, RST, LD0, LD1, LD2, RUN_SOP, RUN, DONE} state_t;

    state_t               state, state_next;
    logic [NB_IMAGE-1:0]  length, length_next;
    logic [NB_IMAGE-1:0]  triple_cnt, triple_cnt_next;
    logic [RCW-1:0]       rst_cnt, rst_cnt_next;
    logic [TCW-1:0]       run_cnt, run_cnt_next;
    logic [GPIO_D-1:0]    word_next;
    logic [RAM_WIDTH-1:0] result_next;
    logic                 done_next, err_next;
    logic [1:0]           ld_sel;
    logic                 unused_rd;

    assign unused_rd = ^i_gpio_rd[GPIO_D-1:RAM_WIDTH];
    assign o_busy    = (state != IDLE);

    function automatic logic [GPIO_D-1:0] make_word(input logic [7:0] ctrl,
                                                    input logic [RAM_WIDTH-1:0] data);
        logic [GPIO_D-1:0] w;
        w                  = '0;
        w[7:0]             = ctrl;
        w[RAM_WIDTH+7:8]   = data;
        return w;
    endfunction

    always_ff @(posedge CLK100MHZ or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            length      <= '0;
            triple_cnt  <= '0;
            rst_cnt     <= '0;
            run_cnt     <= '0;
            o_gpio_word <= '0;
            o_result    <= '0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            state       <= state_next;
            length      <= length_next;
            triple_cnt  <= triple_cnt_next;
            rst_cnt     <= rst_cnt_next;
            run_cnt     <= run_cnt_next;
            o_gpio_word <= word_next;
            o_result    <= result_next;
            o_done      <= done_next;
            o_err       <= err_next;
        end
    end

    // The word computed here is registered, so it reaches the pins one cycle after the state.
    always_comb begin
        state_next      = state;
        length_next     = length;
        triple_cnt_next = triple_cnt;
        rst_cnt_next    = rst_cnt;
        run_cnt_next    = run_cnt;
        word_next       = '0;
        result_next     = o_result;
        done_next       = 1'b0;
        err_next        = 1'b0;
        o_pix_ready     = 1'b0;
        ld_sel          = 2'b00;

        case (state)
            IDLE: begin
                if (i_start) begin
                    if (i_imgLength == '0) begin
                        err_next = 1'b1;
                    end else begin
                        length_next     = i_imgLength;
                        triple_cnt_next = '0;
                        rst_cnt_next    = '0;
                        state_next      = RST;
                    end
                end
            end
            RST: begin
                word_next = make_word(RST_CONV | RST_FSM, RAM_WIDTH'(length));
                if (rst_cnt == RCW'(RST_CYC - 1)) state_next = LD0;
                else rst_cnt_next = rst_cnt + RCW'(1);
            end
            LD0, LD1, LD2: begin
                o_pix_ready = 1'b1;
                ld_sel = (state == LD0) ? 2'b01 : (state == LD1) ? 2'b10 : 2'b11;
                if (i_pix_valid) begin
                    word_next = make_word(LOAD | {1'b0, ld_sel, 5'b0} |
                                          ((state == LD2) ? VALID_FSM : 8'h00), i_pix);
                    case (state)
                        LD0: state_next = LD1;
                        LD1: state_next = LD2;
                        default: begin
                            triple_cnt_next = triple_cnt + NB_IMAGE'(1);
                            state_next = (triple_cnt == length - NB_IMAGE'(1)) ? RUN_SOP : LD0;
                        end
                    endcase
                end else if (o_gpio_word[7]) begin
                    // Stalls repeat the previous load word so the selected memory rewrites in place.
                    word_next = o_gpio_word & ~{{(GPIO_D-8){1'b0}}, VALID_FSM};
                end else begin
                    word_next = make_word(LOAD | {1'b0, ld_sel, 5'b0}, '0);
                end
            end
            RUN_SOP: begin
                word_next    = make_word(K_I | SOP | VALID_FSM, '0);
                run_cnt_next = '0;
                state_next   = RUN;
            end
            RUN: begin
                word_next = make_word(K_I | VALID_FSM, '0);
                if (i_eop) begin
                    result_next = i_gpio_rd[RAM_WIDTH-1:0];
                    done_next   = 1'b1;
                    state_next  = DONE;
                end else if (run_cnt == TCW'(TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    run_cnt_next = run_cnt + TCW'(1);
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_conv_gpio_sequencer.sv
// Scoreboard bench for conv_gpio_sequencer: a transaction model queues the expected load words,
// SOP word and completion/error outcome, and a negedge monitor pops them as the DUT emits them.
module tb_conv_gpio_sequencer;
    localparam int TIMEOUT_TB = 64;
    localparam int K_LOAD = 0, K_SOP = 1, K_DONE = 2, K_ERR = 3;

    logic        CLK100MHZ = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_start = 1'b0;
    logic [9:0]  i_imgLength = '0;
    logic [12:0] i_pix = '0;
    logic        i_pix_valid = 1'b0;
    logic        o_pix_ready;
    logic        i_eop = 1'b0;
    logic [31:0] i_gpio_rd = '0;
    logic [31:0] o_gpio_word;
    logic [12:0] o_result;
    logic        o_busy, o_done, o_err;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   write_cnt = 0;
    bit   last_acc = 0;

    conv_gpio_sequencer #(.TIMEOUT(TIMEOUT_TB)) dut (
        .CLK100MHZ(CLK100MHZ), .i_reset_n(i_reset_n), .i_start(i_start),
        .i_imgLength(i_imgLength), .i_pix(i_pix), .i_pix_valid(i_pix_valid),
        .o_pix_ready(o_pix_ready), .i_eop(i_eop), .i_gpio_rd(i_gpio_rd),
        .o_gpio_word(o_gpio_word), .o_result(o_result), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic popCheck(input int kind, input string name, input logic [31:0] actual);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: unexpected output 0x%08h, expected none at %0t", name, actual, $time);
        end else begin
            e = exp_q.pop_front();
            checkOutput({name, "_kind"}, kind, e.kind);
            checkOutput(name, actual, e.val);
        end
    endtask

    task automatic tick();
        @(posedge CLK100MHZ);
        #1;
    endtask

    always @(negedge CLK100MHZ) begin
        if (!i_reset_n) begin
            last_acc = 0;
        end else begin
            if (last_acc) popCheck(K_LOAD, "load_word", o_gpio_word);
            if (o_gpio_word[3]) popCheck(K_SOP, "sop_word", o_gpio_word);
            if (o_done) popCheck(K_DONE, "done_result", {19'b0, o_result});
            if (o_err) popCheck(K_ERR, "err_busy", {31'b0, o_busy});
            if (o_gpio_word[7] && o_gpio_word[4]) write_cnt++;
            last_acc = o_pix_ready && i_pix_valid;
        end
    end

    // eop_delay < 0 means never raise i_eop; abort_at >= 0 resets the DUT before that pixel.
    task automatic applyStimulus(input int len, input int stall_pct, input int eop_delay,
                                 input logic [31:0] rd, input bit chk_rst, input bit chk_stall,
                                 input int abort_at);
        logic [12:0] pix[$];
        logic [31:0] w, w_p0;
        int          k, cyc, guard, stalls, runc;
        bit          will_acc, stall_now;

        for (int i = 0; i < len * 3; i++) begin
            pix.push_back(13'($urandom_range(0, 8191)));
            w = 32'h80 | (32'(i % 3 + 1) << 5) | (32'(pix[i]) << 8);
            if (i % 3 == 2) w = w | 32'h10;
            exp_q.push_back('{K_LOAD, w});
        end
        w_p0 = 32'hA0 | (32'(pix[0]) << 8);
        if (abort_at < 0) begin
            exp_q.push_back('{K_SOP, 32'h1A});
            if (eop_delay >= 0) exp_q.push_back('{K_DONE, {19'b0, rd[12:0]}});
            else exp_q.push_back('{K_ERR, 32'h0});
        end

        write_cnt   = 0;
        i_gpio_rd   = rd;
        i_imgLength = 10'(len);
        i_start     = 1'b1;
        tick();
        i_start = 1'b0;
        cyc = 0; k = 0; guard = 0; stalls = 0;

        while (k < len * 3 && guard < 2000) begin
            if (k == abort_at) begin
                checkOutput("pre_reset_ready", {31'b0, o_pix_ready}, 32'h1);
                #2 i_reset_n = 1'b0;
                #1;
                checkOutput("async_rst_word", o_gpio_word, 32'h0);
                checkOutput("async_rst_result", {19'b0, o_result}, 32'h0);
                checkOutput("async_rst_flags", {28'b0, o_busy, o_done, o_err, o_pix_ready}, 32'h0);
                i_pix_valid = 1'b0;
                tick();
                i_reset_n = 1'b1;
                exp_q.delete();
                tick();
                return;
            end
            i_pix = pix[k];
            stall_now = chk_stall && (k == 1) && (stalls < 5);
            if (stall_now) begin
                i_pix_valid = 1'b0;
                stalls++;
            end else begin
                i_pix_valid = ($urandom_range(0, 99) >= stall_pct);
            end
            @(negedge CLK100MHZ);
            if (chk_rst && cyc >= 1 && cyc <= 4)
                checkOutput("rst_word", o_gpio_word, (32'(len) << 8) | 32'h5);
            if (chk_rst && cyc == 5) checkOutput("ld0_sel_load", {29'b0, o_gpio_word[7:5]}, 32'h5);
            if (stall_now) checkOutput("stall_word", o_gpio_word, w_p0);
            will_acc = i_pix_valid && o_pix_ready;
            tick();
            cyc++;
            guard++;
            if (will_acc) k++;
        end
        checkOutput("pixels_accepted", k, len * 3);
        i_pix_valid = 1'b0;

        tick();
        runc = 0;
        if (eop_delay >= 0) begin
            repeat (eop_delay) begin
                tick();
                runc++;
            end
            i_eop = 1'b1;
            tick();
            runc++;
            i_eop = 1'b0;
        end
        while (o_busy && runc < 4 * TIMEOUT_TB) begin
            tick();
            runc++;
        end
        checkOutput("run_cycles", runc, (eop_delay >= 0) ? eop_delay + 2 : TIMEOUT_TB);
        repeat (2) tick();
        checkOutput("write_count", write_cnt, len);
        checkOutput("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #2;
        checkOutput("reset_word", o_gpio_word, 32'h0);
        checkOutput("reset_flags", {28'b0, o_busy, o_done, o_err, o_pix_ready}, 32'h0);
        #10 i_reset_n = 1'b1;
        tick();

        // Zero-length start: a single error pulse, never busy, word stays zero.
        exp_q.push_back('{K_ERR, 32'h0});
        i_imgLength = '0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK100MHZ);
            checkOutput("zero_len_busy", {31'b0, o_busy}, 32'h0);
            checkOutput("zero_len_word", o_gpio_word, 32'h0);
            tick();
        end
        checkOutput("zero_len_queue", exp_q.size(), 0);

        applyStimulus(10, 0, 50, 32'h0000_1234, 1, 0, -1);
        applyStimulus(4, 0, TIMEOUT_TB - 1, $urandom, 0, 1, -1);
        applyStimulus(2, 0, -1, 32'h0, 0, 0, -1);
        for (int t = 0; t < 6; t++)
            applyStimulus($urandom_range(1, 5), 30, $urandom_range(0, TIMEOUT_TB - 2), $urandom, 0, 0, -1);
        applyStimulus(2, 0, 5, 32'h0000_0FA5, 0, 0, -1);
        applyStimulus(3, 0, 0, 32'h0, 0, 0, 5);
        applyStimulus(3, 20, 10, 32'h0000_0321, 0, 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
